// File: rtl/strela_mmio_regfile.sv
// strela_mmio_regfile
//   Memory-mapped control/status register file for the STRELA CGRA. It sits
//   between the host register bus and the CGRA main FSM / memory nodes.
//   Provides start/clear control pulses, W1C done status with a masked level
//   interrupt, a configuration base address, per-node IMN/OMN descriptors
//   (write-protected while busy), and four saturating performance counters
//   read coherently through LO/HI word pairs.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   reg_valid_i ..        host bus request (valid/write/addr/wdata/wstrb)
//   reg_rdata_o ..        registered response (rdata/error/ready pulse)
//   start_o               one-cycle start pulse to main FSM
//   conf_change_o         one-cycle configuration-clear pulse
//   exec_done_i           execution-finished pulse
//   conf_done_i           configuration-finished pulse
//   state_conf_i          main FSM in configuration wait state
//   state_exec_i          main FSM in execution state
//   node_req_i/node_gnt_i memory-node bus request/grant vectors
//   irq_o                 level interrupt
//   conf_addr_o           configuration base address
//   imn_addr_o/size/stride flattened IMN descriptors (node i at slice i)
//   omn_addr_o/size       flattened OMN descriptors (node j at slice j)

module strela_mmio_regfile #(
    parameter int unsigned IN_NODES  = 4,
    parameter int unsigned OUT_NODES = 4,
    parameter int unsigned CTR_W     = 48,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      reg_valid_i,
    input  logic                      reg_write_i,
    input  logic [ADDR_W-1:0]         reg_addr_i,
    input  logic [31:0]               reg_wdata_i,
    input  logic [3:0]                reg_wstrb_i,
    output logic [31:0]               reg_rdata_o,
    output logic                      reg_error_o,
    output logic                      reg_ready_o,
    output logic                      start_o,
    output logic                      conf_change_o,
    input  logic                      exec_done_i,
    input  logic                      conf_done_i,
    input  logic                      state_conf_i,
    input  logic                      state_exec_i,
    input  logic [IN_NODES+OUT_NODES-1:0] node_req_i,
    input  logic [IN_NODES+OUT_NODES-1:0] node_gnt_i,
    output logic                      irq_o,
    output logic [31:0]               conf_addr_o,
    output logic [32*IN_NODES-1:0]    imn_addr_o,
    output logic [16*IN_NODES-1:0]    imn_size_o,
    output logic [16*IN_NODES-1:0]    imn_stride_o,
    output logic [32*OUT_NODES-1:0]   omn_addr_o,
    output logic [16*OUT_NODES-1:0]   omn_size_o
);

    localparam int unsigned HI_W = CTR_W - 32;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_IRQEN  = 32'h08;
    localparam logic [31:0] A_CONF   = 32'h0C;
    localparam logic [31:0] A_CTR    = 32'h10;
    localparam logic [31:0] A_NODE   = 32'h40;

    // Byte-strobe merge of a 32-bit register.
    function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] m;
        m = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) m[8*b +: 8] = new_v[8*b +: 8];
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                   resp_q;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q;
    logic                   start_q, conf_change_q, irq_q, irq_d;
    logic                   perf_en_q, perf_en_d;
    logic [1:0]             irq_en_q, irq_en_d;
    logic                   exec_done_q, exec_done_d;
    logic                   conf_done_q, conf_done_d;
    logic                   busy_q, busy_d;
    logic [31:0]            conf_addr_q, conf_addr_d;
    logic [31:0]            imn_addr_q  [IN_NODES];
    logic [31:0]            imn_addr_d  [IN_NODES];
    logic [31:0]            imn_param_q [IN_NODES];
    logic [31:0]            imn_param_d [IN_NODES];
    logic [31:0]            omn_addr_q  [OUT_NODES];
    logic [31:0]            omn_addr_d  [OUT_NODES];
    logic [15:0]            omn_size_q  [OUT_NODES];
    logic [15:0]            omn_size_d  [OUT_NODES];
    logic [3:0][CTR_W-1:0]  ctr_q, ctr_d;
    logic [3:0][HI_W-1:0]   shadow_q, shadow_d;

    // ------------------------------------------------------------------
    // Address decode (all targets are word aligned, so a misaligned
    // address simply matches nothing and reports an error)
    // ------------------------------------------------------------------
    logic [31:0]          addr32;
    logic                 hit_ctrl, hit_status, hit_irqen, hit_conf;
    logic [3:0]           hit_lo, hit_hi;
    logic [IN_NODES-1:0]  hit_imn_addr, hit_imn_param;
    logic [OUT_NODES-1:0] hit_omn_addr, hit_omn_size;
    logic                 prot_hit, mapped, req_err;
    logic                 accept, wr_ok, rd_ok;

    always_comb begin
        addr32     = 32'(reg_addr_i);
        hit_ctrl   = (addr32 == A_CTRL);
        hit_status = (addr32 == A_STATUS);
        hit_irqen  = (addr32 == A_IRQEN);
        hit_conf   = (addr32 == A_CONF);
        hit_lo     = '0;
        hit_hi     = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            hit_lo[k] = (addr32 == A_CTR + 8*k);
            hit_hi[k] = (addr32 == A_CTR + 8*k + 4);
        end
        hit_imn_addr  = '0;
        hit_imn_param = '0;
        for (int unsigned i = 0; i < IN_NODES; i++) begin
            hit_imn_addr[i]  = (addr32 == A_NODE + 8*i);
            hit_imn_param[i] = (addr32 == A_NODE + 8*i + 4);
        end
        hit_omn_addr = '0;
        hit_omn_size = '0;
        for (int unsigned j = 0; j < OUT_NODES; j++) begin
            hit_omn_addr[j] = (addr32 == A_NODE + 8*(IN_NODES + j));
            hit_omn_size[j] = (addr32 == A_NODE + 8*(IN_NODES + j) + 4);
        end
        prot_hit = hit_conf | (|hit_imn_addr) | (|hit_imn_param)
                 | (|hit_omn_addr) | (|hit_omn_size);
        mapped   = hit_ctrl | hit_status | hit_irqen | prot_hit
                 | (|hit_lo) | (|hit_hi);
        req_err  = ~mapped | (reg_write_i & busy_q & prot_hit);
        accept   = reg_valid_i & ~resp_q;
        wr_ok    = accept & reg_write_i & ~req_err;
        rd_ok    = accept & ~reg_write_i & ~req_err;
    end

    // ------------------------------------------------------------------
    // Control actions
    // ------------------------------------------------------------------
    logic ctrl_wr, clr_param, clr_conf, perf_rst, start_go, status_w1c;

    always_comb begin
        ctrl_wr    = wr_ok & hit_ctrl & reg_wstrb_i[0];
        clr_param  = ctrl_wr & reg_wdata_i[1];
        clr_conf   = ctrl_wr & reg_wdata_i[2];
        perf_rst   = ctrl_wr & reg_wdata_i[4];
        // clr_param in the same write suppresses start; start while busy is dropped
        start_go   = ctrl_wr & reg_wdata_i[0] & ~reg_wdata_i[1] & ~busy_q;
        status_w1c = wr_ok & hit_status & reg_wstrb_i[0];

        perf_en_d = perf_en_q;
        if (ctrl_wr) perf_en_d = reg_wdata_i[3];

        irq_en_d = irq_en_q;
        if (wr_ok && hit_irqen && reg_wstrb_i[0]) irq_en_d = reg_wdata_i[1:0];

        busy_d = busy_q;
        if (exec_done_i) busy_d = 1'b0;
        if (start_go)    busy_d = 1'b1;

        // Done pulses are applied last so they win over same-cycle clears.
        exec_done_d = exec_done_q;
        if ((status_w1c && reg_wdata_i[0]) || start_go || clr_param) exec_done_d = 1'b0;
        if (exec_done_i) exec_done_d = 1'b1;

        conf_done_d = conf_done_q;
        if ((status_w1c && reg_wdata_i[1]) || clr_conf) conf_done_d = 1'b0;
        if (conf_done_i) conf_done_d = 1'b1;

        irq_d = (exec_done_q & irq_en_q[0]) | (conf_done_q & irq_en_q[1]);
    end

    // ------------------------------------------------------------------
    // Address/descriptor registers
    // ------------------------------------------------------------------
    always_comb begin
        logic [31:0] tmp;
        tmp = '0;

        conf_addr_d = conf_addr_q;
        if (clr_param)               conf_addr_d = '0;
        else if (wr_ok && hit_conf)  conf_addr_d = merge32(conf_addr_q, reg_wdata_i, reg_wstrb_i);

        for (int unsigned i = 0; i < IN_NODES; i++) begin
            imn_addr_d[i]  = imn_addr_q[i];
            imn_param_d[i] = imn_param_q[i];
            if (clr_param) begin
                imn_addr_d[i]  = '0;
                imn_param_d[i] = '0;
            end else begin
                if (wr_ok && hit_imn_addr[i])
                    imn_addr_d[i] = merge32(imn_addr_q[i], reg_wdata_i, reg_wstrb_i);
                if (wr_ok && hit_imn_param[i])
                    imn_param_d[i] = merge32(imn_param_q[i], reg_wdata_i, reg_wstrb_i);
            end
        end

        for (int unsigned j = 0; j < OUT_NODES; j++) begin
            omn_addr_d[j] = omn_addr_q[j];
            omn_size_d[j] = omn_size_q[j];
            if (clr_param) begin
                omn_addr_d[j] = '0;
                omn_size_d[j] = '0;
            end else begin
                if (wr_ok && hit_omn_addr[j])
                    omn_addr_d[j] = merge32(omn_addr_q[j], reg_wdata_i, reg_wstrb_i);
                if (wr_ok && hit_omn_size[j]) begin
                    tmp           = merge32({16'h0000, omn_size_q[j]}, reg_wdata_i, reg_wstrb_i);
                    omn_size_d[j] = tmp[15:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Performance counters: 0 TOTAL, 1 CONF, 2 EXEC, 3 STALL
    // ------------------------------------------------------------------
    logic [3:0] inc;

    always_comb begin
        inc[0] = 1'b1;
        inc[1] = state_conf_i;
        inc[2] = state_exec_i;
        inc[3] = |(node_req_i & ~node_gnt_i);
        for (int unsigned k = 0; k < 4; k++) begin
            ctr_d[k]    = ctr_q[k];
            shadow_d[k] = shadow_q[k];
            if (perf_rst) begin
                ctr_d[k]    = '0;
                shadow_d[k] = '0;
            end else begin
                if (perf_en_q && inc[k] && !(&ctr_q[k]))
                    ctr_d[k] = ctr_q[k] + CTR_W'(1);
                // LO read freezes the upper bits so the later HI read pairs with it
                if (rd_ok && hit_lo[k])
                    shadow_d[k] = ctr_q[k][CTR_W-1:32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    always_comb begin
        logic [31:0] hi_word;
        rdata_d = '0;
        hi_word = '0;
        if (rd_ok) begin
            if (hit_ctrl)   rdata_d[3]   = perf_en_q;
            if (hit_status) rdata_d[2:0] = {busy_q, conf_done_q, exec_done_q};
            if (hit_irqen)  rdata_d[1:0] = irq_en_q;
            if (hit_conf)   rdata_d      = conf_addr_q;
            for (int unsigned k = 0; k < 4; k++) begin
                if (hit_lo[k]) rdata_d = ctr_q[k][31:0];
                if (hit_hi[k]) begin
                    hi_word             = '0;
                    hi_word[HI_W-1:0]   = shadow_q[k];
                    rdata_d             = hi_word;
                end
            end
            for (int unsigned i = 0; i < IN_NODES; i++) begin
                if (hit_imn_addr[i])  rdata_d = imn_addr_q[i];
                if (hit_imn_param[i]) rdata_d = imn_param_q[i];
            end
            for (int unsigned j = 0; j < OUT_NODES; j++) begin
                if (hit_omn_addr[j]) rdata_d = omn_addr_q[j];
                if (hit_omn_size[j]) rdata_d = {16'h0000, omn_size_q[j]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_q        <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            start_q       <= 1'b0;
            conf_change_q <= 1'b0;
            irq_q         <= 1'b0;
            perf_en_q     <= 1'b0;
            irq_en_q      <= '0;
            exec_done_q   <= 1'b0;
            conf_done_q   <= 1'b0;
            busy_q        <= 1'b0;
            conf_addr_q   <= '0;
            ctr_q         <= '0;
            shadow_q      <= '0;
            for (int unsigned i = 0; i < IN_NODES; i++) begin
                imn_addr_q[i]  <= '0;
                imn_param_q[i] <= '0;
            end
            for (int unsigned j = 0; j < OUT_NODES; j++) begin
                omn_addr_q[j] <= '0;
                omn_size_q[j] <= '0;
            end
        end else begin
            resp_q        <= accept;
            rdata_q       <= rdata_d;
            err_q         <= accept & req_err;
            start_q       <= start_go;
            conf_change_q <= clr_conf;
            irq_q         <= irq_d;
            perf_en_q     <= perf_en_d;
            irq_en_q      <= irq_en_d;
            exec_done_q   <= exec_done_d;
            conf_done_q   <= conf_done_d;
            busy_q        <= busy_d;
            conf_addr_q   <= conf_addr_d;
            ctr_q         <= ctr_d;
            shadow_q      <= shadow_d;
            for (int unsigned i = 0; i < IN_NODES; i++) begin
                imn_addr_q[i]  <= imn_addr_d[i];
                imn_param_q[i] <= imn_param_d[i];
            end
            for (int unsigned j = 0; j < OUT_NODES; j++) begin
                omn_addr_q[j] <= omn_addr_d[j];
                omn_size_q[j] <= omn_size_d[j];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign reg_ready_o   = resp_q;
    assign reg_rdata_o   = rdata_q;
    assign reg_error_o   = err_q;
    assign start_o       = start_q;
    assign conf_change_o = conf_change_q;
    assign irq_o         = irq_q;
    assign conf_addr_o   = conf_addr_q;

    always_comb begin
        imn_addr_o   = '0;
        imn_size_o   = '0;
        imn_stride_o = '0;
        for (int unsigned i = 0; i < IN_NODES; i++) begin
            imn_addr_o[32*i +: 32]   = imn_addr_q[i];
            imn_size_o[16*i +: 16]   = imn_param_q[i][15:0];
            imn_stride_o[16*i +: 16] = imn_param_q[i][31:16];
        end
        omn_addr_o = '0;
        omn_size_o = '0;
        for (int unsigned j = 0; j < OUT_NODES; j++) begin
            omn_addr_o[32*j +: 32] = omn_addr_q[j];
            omn_size_o[16*j +: 16] = omn_size_q[j];
        end
    end

endmodule

// File: doc/strela_mmio_regfile.md
Name: strela_mmio_regfile

Overview:
- Parametrised memory-mapped control/status register file for the STRELA CGRA, sitting between the host register bus and the CGRA main FSM and memory nodes.
- Generalises the fixed 4-IMN/4-OMN control block:
  - node counts are parameters;
  - performance counters have configurable width, saturate, and are read coherently through LO/HI;
  - interrupt output with enable mask;
  - W1C status bits;
  - busy write-protection with bus error.
- Registered single-cycle-latency bus response.

Parameters:
IN_NODES, 4, number of input memory nodes (1..12)
OUT_NODES, 4, number of output memory nodes (1..12)
CTR_W, 48, perf counter width (33..64)
ADDR_W, 8, byte address width of register window

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
reg_valid_i  in  1  bus request valid, held until reg_ready_o
reg_write_i  in  1  1=write, 0=read
reg_addr_i  in  ADDR_W  byte address, word aligned
reg_wdata_i  in  32  write data
reg_wstrb_i  in  4  byte enables
reg_rdata_o  out  32  read data, valid with reg_ready_o
reg_error_o  out  1  error, valid with reg_ready_o
reg_ready_o  out  1  one-cycle response pulse
start_o  out  1  one-cycle start pulse to main FSM
conf_change_o  out  1  one-cycle configuration-clear pulse
exec_done_i  in  1  execution-finished pulse
conf_done_i  in  1  configuration-finished pulse
state_conf_i  in  1  main FSM in configuration wait state
state_exec_i  in  1  main FSM in execution state
node_req_i  in  IN_NODES+OUT_NODES  memory-node bus requests
node_gnt_i  in  IN_NODES+OUT_NODES  memory-node bus grants
irq_o  out  1  level interrupt
conf_addr_o  out  32  configuration base address
imn_addr_o  out  32 x IN_NODES  IMN base addresses
imn_size_o  out  16 x IN_NODES  IMN transfer sizes
imn_stride_o  out  16 x IN_NODES  IMN strides
omn_addr_o  out  32 x OUT_NODES  OMN base addresses
omn_size_o  out  16 x OUT_NODES  OMN sizes

Behaviour:

Reset:
- All registers, counters and outputs are 0.
- Reset mid-transaction drops the pending response; no ready pulse is issued.

Bus protocol:
- A request is accepted when reg_valid_i is high and no response is pending.
- reg_ready_o pulses exactly 1 cycle later, with reg_rdata_o and reg_error_o registered.
- reg_rdata_o is 0 for writes and on error.

Address map (byte offset):

0x00 CTRL:
- b0 start: W1, self-clearing.
- b1 clr_param: W1.
- b2 clr_conf: W1.
- b3 perf_en: RW.
- b4 perf_rst: W1.
- Action bits act only when wstrb[0] is set.
- Readback: perf_en only.

0x04 STATUS:
- b0 exec_done: W1C.
- b1 conf_done: W1C.
- b2 busy: RO.

0x08 IRQ_EN:
- b0 exec.
- b1 conf.

0x0C CONF_ADDR.

Perf counters (LO = bits 31:0, HI = bits CTR_W-1:32):
- 0x10/0x14 TOTAL.
- 0x18/0x1C CONF.
- 0x20/0x24 EXEC.
- 0x28/0x2C STALL.
- Reading LO snapshots the counter's upper bits into a per-counter shadow; reading HI returns that shadow.
- Counters are RO.

Node registers:
- 0x40+8i: IMN i ADDR.
- 0x44+8i: IMN i PARAM, with size = [15:0] and stride = [31:16].
- 0x40+8*IN_NODES+8j: OMN j ADDR.
- 0x44+8*IN_NODES+8j: OMN j SIZE = [15:0].

Unmapped or misaligned addresses:
- reg_error_o=1.
- Writes have no effect.

Write strobes:
- RW registers honour wstrb per byte.

Start and configuration control:
- start (write accepted at cycle T):
  - start_o=1 at T+1;
  - busy set at T+1;
  - exec_done cleared at T+1.
- Start while busy is ignored; no error.
- Start and clr_param in the same write: clr_param applied, start ignored.
- clr_param: zeroes CONF_ADDR and all IMN/OMN registers next cycle; clears exec_done.
- clr_conf: conf_change_o=1 for one cycle; clears conf_done.

Done pulses:
- exec_done_i sets exec_done and clears busy.
- conf_done_i sets conf_done.
- A set pulse wins over a same-cycle W1C or clear.

Busy write-protection:
- While busy, writes to CONF_ADDR and node registers are ignored and return reg_error_o=1.
- CTRL, STATUS and IRQ_EN remain writable while busy.

Perf counters:
- Each counter increments per cycle while perf_en is set and its condition holds:
  - TOTAL: always;
  - CONF: state_conf_i;
  - EXEC: state_exec_i;
  - STALL: any node with req && !gnt.
- Counters saturate at all-ones; no wrap.
- perf_rst zeroes all counters and shadows next cycle, with priority over increment.

Interrupt:
- irq_o is registered: (exec_done & irq_en.exec) | (conf_done & irq_en.conf).
- It follows the status bits with 1-cycle lag.
- It drops 1 cycle after a W1C clear.

Test Plan:
- Reset, then read 0x00..0x2C and all node registers -> all 0, no error; read 0xFC -> error=1, rdata=0.
- Write IMN1 ADDR=0x1234_5678, PARAM=0x0004_0010 -> imn_addr_o[1]=0x12345678, size=16, stride=4; write 0x0000_00FF with wstrb=0001 to IMN1 ADDR -> 0x123456FF.
- Write CTRL=1 -> start_o pulses once, busy=1; write OMN0 ADDR -> error=1, value unchanged; second start -> no start_o pulse; exec_done_i pulse -> STATUS=0x1, busy=0.
- IRQ_EN=1, then exec_done_i -> irq_o high 1 cycle later; W1C STATUS=1 in the same cycle as a new exec_done_i -> bit stays 1; plain W1C later -> irq_o low 1 cycle after.
- CTR_W=33, perf_en=1 for 10 cycles with 3 stall cycles -> TOTAL LO=10, STALL LO=3.
- Force TOTAL near 2^33-1 -> counter saturates at all-ones, HI shadow returns 1 after the LO read.
- perf_rst together with perf_en held -> all counters read 0 the next cycle.
